uart_rx_core: RTL and testbench

//  Standalone UART receiver: receive-side peer of the UART transmit path, for serial links needing RX only.

---
 rtl/uart_rx_core.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampled UART receiver: 2-flop sync, M_TAPS majority vote, optional even parity
// Define UART_RX_BREAK_DET_EN to add the brk output (break-frame detect).
module uart_rx_core #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9_600,
    parameter int PARITY    = 0,
    parameter int DO_WIDTH  = 8,
    parameter int M_TAPS    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic [DO_WIDTH-1:0] dout,
    output logic                dout_vld,
`ifdef UART_RX_BREAK_DET_EN
    output logic                rx_err,
    output logic                brk
`else
    output logic                rx_err
`endif
);

    localparam int BIT_TICKS = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int MID       = BIT_TICKS / 2;
    localparam int HALF      = M_TAPS / 2;
    localparam int CW        = $clog2(BIT_TICKS) + 1;

    localparam logic [CW-1:0] CNT_END  = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] WIN_LO   = CW'(MID - HALF);
    localparam logic [CW-1:0] WIN_HI   = CW'(MID + HALF);
    localparam logic [3:0]    LAST_BIT = 4'(DO_WIDTH - 1);
    localparam logic [3:0]    HALF_V   = 4'(HALF);

    if (BIT_TICKS < 4 * M_TAPS) begin : g_bad_ticks
        $error("uart_rx_core: BIT_TICKS must be at least 4*M_TAPS");
    end
    if ((M_TAPS % 2) == 0 || M_TAPS < 1 || M_TAPS > 15) begin : g_bad_taps
        $error("uart_rx_core: M_TAPS must be odd and within 1..15");
    end
    if (DO_WIDTH < 5 || DO_WIDTH > 9) begin : g_bad_width
        $error("uart_rx_core: DO_WIDTH must be within 5..9");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic                  sync1;
    logic                  rxs;
    logic                  rxs_prev;
    logic [CW-1:0]         cnt;
    logic [3:0]            ones;
    logic [3:0]            tally;
    logic [3:0]            bit_idx;
    logic [DO_WIDTH-1:0]   shreg;
    logic                  par_bit;
    logic                  fall;
    logic                  in_win;
    logic                  at_dec;
    logic                  at_end;
    logic                  vote;
    logic                  shift_en;
    logic                  par_cap;
    logic                  frame_done;
    logic                  frame_bad;
    logic                  cnt_clr;

    assign fall   = rxs_prev & ~rxs;
    assign in_win = (cnt >= WIN_LO) && (cnt <= WIN_HI);
    assign at_dec = (cnt == WIN_HI);
    assign at_end = (cnt == CNT_END);
    // The decision-count sample is folded in combinationally so the vote is ready that cycle.
    assign tally  = ones + {3'b000, rxs};
    assign vote   = (tally > HALF_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (fall) state_nx = S_START;
            S_START: begin
                if (at_dec && vote) begin
                    state_nx = S_IDLE;
                end else if (at_end) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (at_end && (bit_idx == LAST_BIT)) begin
                    state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (at_end) state_nx = S_STOP;
            // Leaving the stop bit at its decision point leaves half a bit of slack for baud mismatch.
            S_STOP:   if (at_dec) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        shift_en   = 1'b0;
        par_cap    = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_DATA:   shift_en   = at_dec;
            S_PARITY: par_cap    = at_dec;
            S_STOP:   frame_done = at_dec;
            default:  ;
        endcase
    end

    assign frame_bad = ~vote | ((PARITY != 0) && ((^shreg) ^ par_bit));
    assign cnt_clr   = (state == S_IDLE) || (state_nx != state) || at_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
            cnt      <= '0;
            ones     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            dout     <= '0;
            dout_vld <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            sync1    <= rx;
            rxs      <= sync1;
            rxs_prev <= rxs;
            dout_vld <= 1'b0;
            rx_err   <= 1'b0;
            cnt      <= cnt_clr ? '0 : cnt + 1'b1;
            ones     <= in_win ? tally : '0;
            if (state != S_DATA) begin
                bit_idx <= '0;
            end else if (at_end) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) begin
                shreg <= {vote, shreg[DO_WIDTH-1:1]};
            end
            if (par_cap) begin
                par_bit <= vote;
            end
            if (frame_done) begin
                dout <= shreg;
                if (frame_bad) begin
                    rx_err <= 1'b1;
                end else begin
                    dout_vld <= 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic brk_frame;

    assign brk_frame = frame_done && (shreg == '0) && !vote && !((PARITY != 0) && par_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            brk <= 1'b0;
        end else if (brk_frame) begin
            brk <= 1'b1;
        end else if (rxs) begin
            brk <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - randomized self-checking bench for uart_rx_core against a frame-level model
module tb_uart_rx_core;

    localparam int BIT  = 100;
    localparam int MID  = BIT / 2;
    localparam int HALF = 1;
    localparam int LAT  = 2 + 9 * BIT + MID + HALF + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] dout0, dout1;
    logic       dout_vld0, dout_vld1, rx_err0, rx_err1;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk0, brk1;
`endif

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         t_start0 = 0;
    int         last_lat = 0;
    int         vld_cnt [2] = '{0, 0};
    int         err_cnt [2] = '{0, 0};
    logic [7:0] last_dout [2] = '{8'h00, 8'h00};
    logic [8:0] exp_q0 [$];
    logic [8:0] exp_q1 [$];

    always #5 clk = ~clk;

    uart_rx_core #(.CLK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .PARITY(0), .DO_WIDTH(8), .M_TAPS(3)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .dout(dout0), .dout_vld(dout_vld0),
`ifdef UART_RX_BREAK_DET_EN
        .rx_err(rx_err0), .brk(brk0)
`else
        .rx_err(rx_err0)
`endif
    );

    uart_rx_core #(.CLK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .PARITY(1), .DO_WIDTH(8), .M_TAPS(3)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .dout(dout1), .dout_vld(dout_vld1),
`ifdef UART_RX_BREAK_DET_EN
        .rx_err(rx_err1), .brk(brk1)
`else
        .rx_err(rx_err1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Every pulse must match the oldest expected frame; between pulses dout must hold.
    task automatic check_dut(input int id, input logic [7:0] d, input logic v, input logic e);
        logic [8:0] ex;
        tests++;
        if (v !== 1'b0 || e !== 1'b0) begin
            if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
                fails++;
                $display("FAIL stray_pulse dut%0d: got vld=%b err=%b dout=0x%02h, required no pulse", id, v, e, d);
            end else begin
                ex = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                if (v !== !ex[8] || e !== ex[8] || d !== ex[7:0]) begin
                    fails++;
                    $display("FAIL frame dut%0d: got vld=%b err=%b dout=0x%02h, required vld=%b err=%b dout=0x%02h",
                             id, v, e, d, !ex[8], ex[8], ex[7:0]);
                end
                last_dout[id] = ex[7:0];
                if (ex[8]) err_cnt[id]++;
                else vld_cnt[id]++;
                if (id == 0 && v === 1'b1) last_lat = cyc - t_start0;
            end
        end else if (d !== last_dout[id]) begin
            fails++;
            $display("FAIL dout_hold dut%0d: got 0x%02h, required 0x%02h", id, d, last_dout[id]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            check_dut(0, dout0, dout_vld0, rx_err0);
            check_dut(1, dout1, dout_vld1, rx_err1);
        end
    end

    task automatic set_rx(input int id, input logic v);
        if (id == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic drive(input int id, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_rx(id, v);
        end
    endtask

    // Frame: start, 8 data LSB first, even parity (dut1 only), stop. Line is left at the stop value.
    task automatic send(input int id, input logic [7:0] data, input bit par_ok, input bit stop,
                        input int period, input int spike_at, input int rst_at);
        logic [10:0] bits;
        int          nb;
        logic        pbit;
        logic        v;
        pbit = (^data) ^ !par_ok;
        if (id == 0) begin
            bits = {2'b00, stop, data, 1'b0};
            nb   = 10;
        end else begin
            bits = {1'b0, stop, pbit, data, 1'b0};
            nb   = 11;
        end
        if (rst_at < 0) begin
            if (id == 0) exp_q0.push_back({!stop, data});
            else exp_q1.push_back({!stop || !par_ok, data});
        end
        for (int i = 0; i < nb * period; i++) begin
            @(negedge clk);
            if (i == 0 && id == 0) t_start0 = cyc + 1;
            v = bits[i / period] ^ (i == spike_at);
            set_rx(id, v);
            if (i == rst_at) begin
                rst = 1'b1;
                last_dout[0] = 8'h00;
                last_dout[1] = 8'h00;
                @(negedge clk);
                rst = 1'b0;
                set_rx(id, 1'b1);
                return;
            end
        end
    endtask

    initial begin
        int v0, e0;
        logic [7:0] d;
        bit po, st;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_dout", dout0, 0);
        chk("reset_vld", dout_vld0, 0);
        chk("reset_err", rx_err0, 0);
        drive(0, 1'b1, 10);

        send(0, 8'h64, 1, 1, BIT, -1, -1);
        drive(0, 1'b1, 100);
        chk("t1_vld_cnt", vld_cnt[0], 1);
        chk("t1_err_cnt", err_cnt[0], 0);
        chk("t1_dout", dout0, 8'h64);
        chk("t1_latency", last_lat, LAT);

        send(1, 8'hC8, 1, 1, BIT, -1, -1);
        drive(1, 1'b1, 100);
        chk("t2_good_vld", vld_cnt[1], 1);
        chk("t2_good_dout", dout1, 8'hC8);
        send(1, 8'hC8, 0, 1, BIT, -1, -1);
        drive(1, 1'b1, 100);
        chk("t2_bad_err", err_cnt[1], 1);
        chk("t2_bad_vld", vld_cnt[1], 1);
        chk("t2_bad_dout", dout1, 8'hC8);

        send(0, 8'h55, 1, 0, BIT, -1, -1);
        drive(0, 1'b0, 300);
        drive(0, 1'b1, 300);
        chk("t3_ferr_err", err_cnt[0], 1);
        chk("t3_ferr_vld", vld_cnt[0], 1);
        chk("t3_ferr_dout", dout0, 8'h55);

`ifdef UART_RX_BREAK_DET_EN
        send(0, 8'h00, 1, 0, BIT, -1, -1);
        drive(0, 1'b0, 300);
        chk("t3_brk_set", brk0, 1);
        drive(0, 1'b1, 10);
        chk("t3_brk_clr", brk0, 0);
        drive(0, 1'b1, 100);
`endif

        v0 = vld_cnt[0];
        e0 = err_cnt[0];
        drive(0, 1'b0, 20);
        drive(0, 1'b1, 200);
        chk("t4_glitch_vld", vld_cnt[0], v0);
        chk("t4_glitch_err", err_cnt[0], e0);
        send(0, 8'hA5, 1, 1, BIT, -1, -1);
        drive(0, 1'b1, 100);
        chk("t4_after_dout", dout0, 8'hA5);

        // Spike lands on the middle vote sample of data bit 3 after the sync/edge delay.
        send(0, 8'h0F, 1, 1, BIT, 4 * BIT + MID + 1, -1);
        drive(0, 1'b1, 100);
        chk("t5_spike_dout", dout0, 8'h0F);

        v0 = vld_cnt[0];
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 10; k++) begin
                d = 8'($urandom);
                send(0, d, 1, 1, (p == 0) ? 98 : 102, -1, -1);
            end
            drive(0, 1'b1, 100);
        end
        chk("t5_sweep_count", vld_cnt[0] - v0, 20);

        v0 = vld_cnt[0];
        e0 = err_cnt[0];
        send(0, 8'h3C, 1, 1, BIT, 350, 350);
        chk("t6_rst_dout", dout0, 0);
        chk("t6_rst_vld", dout_vld0, 0);
        chk("t6_rst_err", rx_err0, 0);
        drive(0, 1'b1, 200);
        chk("t6_no_pulse", (vld_cnt[0] - v0) + (err_cnt[0] - e0), 0);
        send(0, 8'hC3, 1, 1, BIT, -1, -1);
        drive(0, 1'b1, 100);
        chk("t6_after_dout", dout0, 8'hC3);

        for (int k = 0; k < 8; k++) begin
            d  = 8'($urandom);
            po = 1'($urandom);
            st = ($urandom_range(0, 3) != 0);
            send(1, d, po, st, BIT, -1, -1);
            drive(1, 1'b1, $urandom_range(20, 80));
        end

        drive(0, 1'b1, 200);
        chk("final_q0_empty", exp_q0.size(), 0);
        chk("final_q1_empty", exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
